// File: rtl/ysyx_pcu.sv
// ysyx_pcu: program counter unit. Issues sequential fetch addresses, tracks
// in-flight fetches in a small FIFO of {pc, predicted next pc}, checks each
// retired instruction against the FIFO head and redirects, flushes or halts.
module ysyx_pcu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wb_valid,
  input  logic [XLEN-1:0]              wb_rpc,
  input  logic [XLEN-1:0]              wb_npc,
  input  logic                         wb_retire,
  input  logic                         wb_ebreak,
  input  logic                         ifu_ready,
  output logic [XLEN-1:0]              pc,
  output logic                         pc_valid,
  output logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic                         halted,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH, HALT} state_t;

  // Sequential fetch step; wraps modulo 2^XLEN by construction.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] a);
    return a + XLEN'(4);
  endfunction

  // FIFO pointer step; DEPTH is a power of two so the natural wrap is modulo DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1);
  endfunction

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   wptr, wptr_nxt, rptr, rptr_nxt;
  logic            err_nxt;
  logic            push;

  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] fifo_pnpc [DEPTH];

  logic fire, pop, wb_empty, redirect, halt_go;

  assign pc_valid = (state == FETCH) && (cnt < DEPTH_C);
  assign flush    = (state == FLUSH);
  assign halted   = (state == HALT);
  assign inflight = cnt;

  assign fire     = pc_valid & ifu_ready;
  assign pop      = wb_valid & (state == FETCH) & (cnt != '0);
  assign wb_empty = wb_valid & (state == FETCH) & (cnt == '0);
  assign halt_go  = pop & wb_ebreak;
  assign redirect = pop & ~wb_ebreak &
                    (wb_retire | (wb_npc != fifo_pnpc[rptr]));

  // Next-state, pc, occupancy and error decisions.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    err_nxt   = err;
    push      = 1'b0;
    if (wb_empty || (pop && (wb_rpc != fifo_pc[rptr]))) err_nxt = 1'b1;
    case (state)
      BOOT:  state_nxt = FETCH;
      FLUSH: state_nxt = FETCH;
      HALT:  state_nxt = HALT;
      FETCH: begin
        if (halt_go) begin
          state_nxt = HALT;
          rptr_nxt  = ptr_inc(rptr);
          cnt_nxt   = cnt - CW'(1);
        end else if (redirect) begin
          state_nxt = FLUSH;
          pc_nxt    = wb_npc;
          cnt_nxt   = '0;
          wptr_nxt  = '0;
          rptr_nxt  = '0;
        end else begin
          if (fire) begin
            push     = 1'b1;
            pc_nxt   = pc_inc(pc);
            wptr_nxt = ptr_inc(wptr);
          end
          if (pop) rptr_nxt = ptr_inc(rptr);
          if (fire && !pop)      cnt_nxt = cnt + CW'(1);
          else if (!fire && pop) cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Control state register; reset overrides every same-cycle event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
      cnt   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      err   <= err_nxt;
    end
  end

  // FIFO storage; occupancy is governed by the pointers, so no reset needed.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      fifo_pc[wptr]   <= pc;
      fifo_pnpc[wptr] <= pc_inc(pc);
    end
  end

endmodule

// File: doc/ysyx_pcu.md
YSYX_PCU -- requirements
Module: ysyx_pcu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath and PC width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the maximum number of in-flight fetches (power of two, at least 2).
REQ-004 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port wb_valid, input, 1 bit: a writeback result is present this cycle (single-cycle pulse per retired instruction).
REQ-007 The block SHALL have port wb_rpc, input, XLEN bits: PC of the retired instruction.
REQ-008 The block SHALL have port wb_npc, input, XLEN bits: architecturally correct next PC of the retired instruction.
REQ-009 The block SHALL have port wb_retire, input, 1 bit: system instruction retired, which forces a redirect.
REQ-010 The block SHALL have port wb_ebreak, input, 1 bit: the retired instruction is ebreak.
REQ-011 The block SHALL have port ifu_ready, input, 1 bit: the fetch unit accepts pc this cycle.
REQ-012 The block SHALL have port pc, output, XLEN bits: fetch address.
REQ-013 The block SHALL have port pc_valid, output, 1 bit: pc is offered to the fetch unit.
REQ-014 The block SHALL have port flush, output, 1 bit: kill all younger in-flight instructions.
REQ-015 The block SHALL have port inflight, output, clog2(DEPTH+1) bits: count of issued but not yet retired fetches.
REQ-016 The block SHALL have port halted, output, 1 bit: the block is in the HALT state.
REQ-017 The block SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-018 The block SHALL implement the FSM states BOOT, FETCH, FLUSH and HALT.
REQ-019 BOOT SHALL last exactly one cycle, drive pc_valid=0, and then go to FETCH.
REQ-020 In FETCH, pc_valid SHALL equal (inflight < DEPTH), driven combinationally from state and count; pc_valid SHALL be 0 in all other states.
REQ-021 A fire SHALL occur when pc_valid and ifu_ready are both 1; on a fire the block SHALL push {pc, pc+4} into a DEPTH-entry FIFO, set pc to pc+4, and increment inflight.
REQ-022 pc+4 SHALL wrap modulo 2^XLEN; at pc=32'hFFFF_FFFC the next pc SHALL be 0.
REQ-023 On wb_valid in FETCH with inflight>0, the block SHALL pop the FIFO head.
REQ-024 On a pop, if wb_rpc differs from head.pc, err SHALL be set and processing SHALL continue normally.
REQ-025 If a pop is not a redirect, a fire in the same cycle SHALL leave inflight unchanged, with push and pop both performed.
REQ-026 A pop SHALL be a redirect if wb_retire=1 or wb_npc differs from head.pnpc.
REQ-027 On a redirect the next cycle SHALL have pc=wb_npc, the FIFO empty, inflight=0 and state FLUSH; any same-cycle fire SHALL be discarded (not pushed).
REQ-028 FLUSH SHALL last exactly one cycle with flush=1 and pc_valid=0, then go to FETCH; flush SHALL be 0 in every other state.
REQ-029 wb_valid with wb_ebreak=1 in FETCH SHALL take priority over a redirect: pop, go to HALT, and hold pc unchanged; HALT SHALL be exited only by reset.
REQ-030 wb_valid in FETCH with inflight=0 SHALL set err and SHALL otherwise be ignored.
REQ-031 wb_valid in BOOT, FLUSH or HALT SHALL be ignored and SHALL NOT set err.
REQ-032 err SHALL stay at 1 until reset once set.
REQ-033 halted SHALL be 1 exactly when state is HALT.
REQ-034 The FIFO read and write pointers SHALL wrap modulo DEPTH; inflight SHALL never exceed DEPTH.

Reset
REQ-035 On reset, the block SHALL set state=BOOT, pc=RESET_PC, pc_valid=0, flush=0, inflight=0, halted=0, err=0, and empty the FIFO.
REQ-036 Reset SHALL override all same-cycle events, including a fire, wb_valid or ebreak, and SHALL apply from any state, including HALT and FLUSH.

Verification
REQ-037 Boot and stream check: release reset with ifu_ready=1 and no wb -> pc_valid=0 in cycle 1; then pc 8000_0000, 8000_0004, 8000_0008, 8000_000C on consecutive cycles; then pc_valid=0 with inflight=4.
REQ-038 Steady-state retire check: DEPTH full, wb_valid with rpc=8000_0000 and npc=8000_0004 while ifu_ready=1 -> pop plus push, inflight stays 4, pc advances to 8000_0014, flush=0.
REQ-039 Branch redirect check: head pnpc=8000_0004 but wb_npc=8000_0100 -> next cycle flush=1, pc_valid=0, inflight=0; the cycle after that pc=8000_0100 and pc_valid=1.
REQ-040 System-retire and ebreak check: wb_retire=1 with matching npc -> FLUSH is still taken; wb_ebreak=1 together with a mismatching npc -> halted=1, flush=0, pc_valid stays 0, and reset returns the block to BOOT.
REQ-041 Error and wrap check: wb_valid at inflight=0 -> err=1, sticky; wb_rpc mismatch -> err=1; RESET_PC=32'hFFFF_FFFC -> second fetch pc=0.
